// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, requests instruction words, latches them for the decoder and
// computes the next PC from decoder controls. Optional retired counter: FETCH_INSTR_COUNT_EN.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          WAIT_LIMIT = 16
) (
   input  logic        clk,
   input  logic        rst_b,
   output logic [31:0] imem_addr,
   output logic        imem_req,
   input  logic        imem_ready,
   input  logic [31:0] imem_data,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic [5:0]  func,
   output logic        instr_valid,
   input  logic        decode_ready,
   input  logic        Jump,
   input  logic        JumpReg,
   input  logic        Branch,
   input  logic        branch_taken,
   input  logic [31:0] imm_ext,
   input  logic [31:0] reg_target,
   input  logic        Halted,
   output logic [31:0] pc,
   output logic        halted,
   output logic        fetch_timeout,
`ifdef FETCH_INSTR_COUNT_EN
   output logic [31:0] retired_count,
`endif
   output logic [1:0]  o_dbg_state
);

   // Handshake: imem_data is taken only on a cycle with imem_req=1 and imem_ready=1;
   // the held instr is consumed only on a cycle with instr_valid=1 and decode_ready=1.

   localparam int CW = $clog2(WAIT_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_ISSUE = 2'd1,
      S_HALT  = 2'd2
   } state_t;

   state_t        r_state;
   logic [31:0]   r_pc;
   logic [31:0]   r_instr;
   logic          r_imem_req;
   logic          r_instr_valid;
   logic          r_halted;
   logic          r_timeout;
   logic [CW-1:0] r_wait;
`ifdef FETCH_INSTR_COUNT_EN
   logic [31:0]   r_retired;
`endif

   logic [31:0]   w_pc4;
   logic [31:0]   w_next_pc;
   logic [CW-1:0] w_wait_inc;

   assign w_pc4      = r_pc + 32'd4;
   assign w_wait_inc = r_wait + CW'(1);

   always_comb begin
      w_next_pc = w_pc4;
      if (Jump && JumpReg)
         w_next_pc = reg_target;
      else if (Jump)
         w_next_pc = {w_pc4[31:28], r_instr[25:0], 2'b00};
      else if (Branch && branch_taken)
         w_next_pc = w_pc4 + (imm_ext << 2);
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state       <= S_FETCH;
         r_pc          <= RESET_PC;
         r_instr       <= 32'd0;
         r_imem_req    <= 1'b1;
         r_instr_valid <= 1'b0;
         r_halted      <= 1'b0;
         r_timeout     <= 1'b0;
         r_wait        <= '0;
`ifdef FETCH_INSTR_COUNT_EN
         r_retired     <= 32'd0;
`endif
      end else begin
         case (r_state)
            S_FETCH: begin
               if (imem_ready) begin
                  r_instr       <= imem_data;
                  r_state       <= S_ISSUE;
                  r_imem_req    <= 1'b0;
                  r_instr_valid <= 1'b1;
               end else if (r_wait != LIMIT) begin
                  // Timeout flags the cycle the counter lands on the limit; the fetch keeps waiting.
                  r_wait <= w_wait_inc;
                  if (w_wait_inc == LIMIT)
                     r_timeout <= 1'b1;
               end
            end
            S_ISSUE: begin
               if (decode_ready) begin
`ifdef FETCH_INSTR_COUNT_EN
                  r_retired <= r_retired + 32'd1;
`endif
                  r_instr_valid <= 1'b0;
                  if (Halted) begin
                     r_state  <= S_HALT;
                     r_halted <= 1'b1;
                  end else begin
                     r_pc       <= w_next_pc;
                     r_wait     <= '0;
                     r_state    <= S_FETCH;
                     r_imem_req <= 1'b1;
                  end
               end
            end
            S_HALT: begin
               r_state <= S_HALT;
            end
            default: begin
               r_state       <= S_FETCH;
               r_imem_req    <= 1'b1;
               r_instr_valid <= 1'b0;
            end
         endcase
      end
   end

   assign imem_addr     = r_pc;
   assign pc            = r_pc;
   assign imem_req      = r_imem_req;
   assign instr         = r_instr;
   assign opcode        = r_instr[31:26];
   assign func          = r_instr[5:0];
   assign instr_valid   = r_instr_valid;
   assign halted        = r_halted;
   assign fetch_timeout = r_timeout;
   assign o_dbg_state   = r_state;
`ifdef FETCH_INSTR_COUNT_EN
   assign retired_count = r_retired;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, jump/branch/JR targets, stall,
// halt, fetch timeout and asynchronous reset.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_b;
   logic [31:0] imem_addr;
   logic        imem_req;
   logic        imem_ready;
   logic [31:0] imem_data;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [5:0]  func;
   logic        instr_valid;
   logic        decode_ready;
   logic        Jump;
   logic        JumpReg;
   logic        Branch;
   logic        branch_taken;
   logic [31:0] imm_ext;
   logic [31:0] reg_target;
   logic        Halted;
   logic [31:0] pc;
   logic        halted;
   logic        fetch_timeout;
   logic [1:0]  dbg_state;
`ifdef FETCH_INSTR_COUNT_EN
   logic [31:0] retired_count;
`endif

   int n_total = 0;
   int n_bad   = 0;
   logic [31:0] exp_q[$];

   instr_fetch_unit #(.RESET_PC(32'h0), .WAIT_LIMIT(16)) dut (
      .clk          (clk),
      .rst_b        (rst_b),
      .imem_addr    (imem_addr),
      .imem_req     (imem_req),
      .imem_ready   (imem_ready),
      .imem_data    (imem_data),
      .instr        (instr),
      .opcode       (opcode),
      .func         (func),
      .instr_valid  (instr_valid),
      .decode_ready (decode_ready),
      .Jump         (Jump),
      .JumpReg      (JumpReg),
      .Branch       (Branch),
      .branch_taken (branch_taken),
      .imm_ext      (imm_ext),
      .reg_target   (reg_target),
      .Halted       (Halted),
      .pc           (pc),
      .halted       (halted),
      .fetch_timeout(fetch_timeout),
`ifdef FETCH_INSTR_COUNT_EN
      .retired_count(retired_count),
`endif
      .o_dbg_state  (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_ctrl();
      decode_ready = 1'b0;
      Jump         = 1'b0;
      JumpReg      = 1'b0;
      Branch       = 1'b0;
      branch_taken = 1'b0;
      Halted       = 1'b0;
      imm_ext      = 32'd0;
      reg_target   = 32'd0;
   endtask

   // Called at a negedge while the DUT is in S_FETCH; returns at the negedge in S_ISSUE.
   task automatic fetch_word(input logic [31:0] w);
      imem_ready = 1'b1;
      imem_data  = w;
      @(negedge clk);
      imem_ready = 1'b0;
      imem_data  = 32'd0;
   endtask

   task automatic accept(input logic j, input logic jr, input logic br, input logic bt,
                         input logic h, input logic [31:0] imm, input logic [31:0] rt);
      Jump         = j;
      JumpReg      = jr;
      Branch       = br;
      branch_taken = bt;
      Halted       = h;
      imm_ext      = imm;
      reg_target   = rt;
      decode_ready = 1'b1;
      @(negedge clk);
      clear_ctrl();
   endtask

   task automatic jr_to(input logic [31:0] t);
      fetch_word(32'd0);
      accept(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, t);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pc"},      pc,            32'd0);
      chk({tag, "_addr"},    imem_addr,     32'd0);
      chk({tag, "_req"},     imem_req,      1'b1);
      chk({tag, "_valid"},   instr_valid,   1'b0);
      chk({tag, "_halted"},  halted,        1'b0);
      chk({tag, "_timeout"}, fetch_timeout, 1'b0);
      chk({tag, "_instr"},   instr,         32'd0);
      chk({tag, "_state"},   dbg_state,     2'd0);
   endtask

   initial begin
      rst_b      = 1'b0;
      imem_ready = 1'b0;
      imem_data  = 32'd0;
      clear_ctrl();
      #12;
      chk_reset_vals("rst");
      @(negedge clk);
      rst_b = 1'b1;

      // Zero-wait sequential fetch: two cycles per instruction, addresses 0,4,8.
      exp_q = {32'h0, 32'h4, 32'h8};
      imem_ready   = 1'b1;
      decode_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk("seq_valid", instr_valid, (i % 2 == 1));
         chk("seq_req", imem_req, (i % 2 == 0));
         if (i % 2 == 0) chk("seq_addr", imem_addr, exp_q.pop_front());
         @(negedge clk);
      end
      imem_ready   = 1'b0;
      decode_ready = 1'b0;
      chk("seq_next_pc", pc, 32'hC);
`ifdef FETCH_INSTR_COUNT_EN
      chk("retired3", retired_count, 32'd3);
`endif

      // Absolute jump.
      jr_to(32'h1000_0000);
      chk("jr_pc", pc, 32'h1000_0000);
      fetch_word(32'h0810_0004);
      chk("j_instr", instr, 32'h0810_0004);
      chk("j_opcode", opcode, 6'h02);
      chk("j_func", func, 6'h04);
      accept(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      chk("j_addr", imem_addr, 32'h1040_0010);

      // Branch taken backwards / not taken.
      jr_to(32'h20);
      fetch_word(32'h1000_FFFE);
      accept(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'd0);
      chk("br_taken", pc, 32'h1C);
      jr_to(32'h20);
      fetch_word(32'h1000_FFFE);
      accept(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'd0);
      chk("br_not_taken", pc, 32'h24);

      // JR target, PC wrap, misaligned JR.
      jr_to(32'h400);
      chk("jr_400", pc, 32'h400);
      jr_to(32'hFFFF_FFFC);
      fetch_word(32'd0);
      accept(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      chk("pc_wrap", pc, 32'd0);
      jr_to(32'h3);
      chk("jr_misaligned", pc, 32'h3);

      // Stall with decode_ready=0; controls and imem_ready must be ignored.
      fetch_word(32'hABCD_1234);
      Jump = 1'b1; Branch = 1'b1; branch_taken = 1'b1;
      imem_ready = 1'b1; imem_data = 32'hFFFF_FFFF;
      for (int i = 0; i < 5; i++) begin
         chk("stall_instr", instr, 32'hABCD_1234);
         chk("stall_opcode", opcode, 6'h2A);
         chk("stall_func", func, 6'h34);
         chk("stall_pc", pc, 32'h3);
         chk("stall_req", imem_req, 1'b0);
         chk("stall_valid", instr_valid, 1'b1);
         @(negedge clk);
      end
      imem_ready = 1'b0;
      clear_ctrl();

      // Halted beats Jump; fetch stops for good.
      accept(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'h0000_0800);
      chk("halt_flag", halted, 1'b1);
      chk("halt_state", dbg_state, 2'd2);
      imem_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("halt_req", imem_req, 1'b0);
         chk("halt_valid", instr_valid, 1'b0);
         chk("halt_pc", pc, 32'h3);
         chk("halt_hold", halted, 1'b1);
         @(negedge clk);
      end
      imem_ready = 1'b0;

      // Reset out of halt.
      rst_b = 1'b0;
      #1;
      chk_reset_vals("rst_halt");
      @(negedge clk);
      rst_b = 1'b1;

      // Fetch timeout after 16 waiting cycles, sticky.
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         chk("timeout", fetch_timeout, (i >= 16));
         chk("timeout_req", imem_req, 1'b1);
      end
      #2;
      rst_b = 1'b0;
      #1;
      chk_reset_vals("rst_wait");
      @(negedge clk);
      rst_b = 1'b1;

      // Reset mid-issue discards the held instruction.
      fetch_word(32'h1234_5678);
      chk("issue_valid", instr_valid, 1'b1);
      chk("issue_instr", instr, 32'h1234_5678);
      #2;
      rst_b = 1'b0;
      #1;
      chk_reset_vals("rst_issue");
      @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Sequential fetch stage directly upstream of the control unit.
- Holds the PC, issues requests to instruction memory, and latches the returned word.
- Presents opcode[31:26] and func[5:0] to the decoder.
- Consumes the decoder's Jump/JumpReg/Branch/Halted outputs to compute the next PC, or to stop fetching.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- WAIT_LIMIT, 16, imem cycles waited before the fetch-timeout flag is raised (no abort).

Ports:
- clk  input  1  clock, rising-edge.
- rst_b  input  1  asynchronous active-low reset.
- imem_addr  output  32  fetch address (equals pc).
- imem_req  output  1  fetch request.
- imem_ready  input  1  imem_data valid this cycle.
- imem_data  input  32  fetched instruction word.
- instr  output  32  latched instruction.
- opcode  output  6  instr[31:26].
- func  output  6  instr[5:0].
- instr_valid  output  1  instr is held for the decoder/execute stage.
- decode_ready  input  1  downstream accepts the held instruction this cycle.
- Jump  input  1  decoder Jump.
- JumpReg  input  1  decoder JumpReg.
- Branch  input  1  decoder Branch.
- branch_taken  input  1  ALU zero flag for the held branch.
- imm_ext  input  32  extended immediate of the held instruction.
- reg_target  input  32  rs value for JR.
- Halted  input  1  decoder Halted.
- pc  output  32  current PC.
- halted  output  1  fetch stopped.
- fetch_timeout  output  1  sticky; set when a request has waited WAIT_LIMIT cycles.

Behaviour:
Reset (rst_b low, asynchronous):
- state=S_FETCH, pc=RESET_PC, instr=0, halted=0, fetch_timeout=0, wait counter=0.
- imem_req is 1 from the first cycle out of reset.

States:
- S_FETCH:
  - imem_req=1, instr_valid=0.
  - On imem_ready: instr<=imem_data, go to S_ISSUE.
  - Otherwise the wait counter increments, saturating at WAIT_LIMIT.
  - When the counter reaches WAIT_LIMIT, set fetch_timeout (sticky until reset).
- S_ISSUE:
  - imem_req=0, instr_valid=1.
  - instr, opcode and func are stable.
  - Control inputs are sampled only on a cycle with decode_ready=1.
  - On acceptance: if Halted, go to S_HALT with halted=1 and pc unchanged. Otherwise pc<=next_pc, wait counter cleared, go to S_FETCH.
- S_HALT:
  - imem_req=0, instr_valid=0, halted=1.
  - Only reset leaves this state.

next_pc, in priority order:
- Jump&JumpReg: reg_target.
- Jump: {pc4[31:28], instr[25:0], 2'b00}.
- Branch&branch_taken: pc4 + (imm_ext<<2).
- Otherwise: pc4.
- pc4 = pc+4, modulo 2^32; wrap from 32'hFFFF_FFFC gives 0.
- The JAL link value is not produced here.

Boundary conditions:
- Latency: zero-wait memory gives minimum 2 cycles per instruction (fetch cycle, issue cycle).
- imem_ready outside S_FETCH is ignored.
- Halted together with Jump/Branch: Halted wins.
- Reset asserted mid-fetch or mid-issue discards the in-flight instruction.
- Branch with branch_taken=0 advances to pc4.
- Misaligned reg_target is loaded unchanged.

Optional Feature:
- Macro: FETCH_INSTR_COUNT_EN.
- With the macro:
  - Extra output retired_count[31:0], reset to 0.
  - Increments by 1 on each accepted S_ISSUE cycle, including the halting instruction.
  - Wraps at 2^32.
- Without the macro: port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset release, imem_ready=1 every cycle, decode_ready=1, no control: imem_addr sequence 0,4,8; instr_valid every 2nd cycle.
- Held word 32'h0810_0004 with Jump=1 at pc=32'h1000_0000: next imem_addr=32'h1040_0010.
- Branch=1, branch_taken=1, imm_ext=32'hFFFF_FFFE at pc=32'h20: next pc=32'h1C. Same stimulus with branch_taken=0: next pc=32'h24.
- Jump=1, JumpReg=1, reg_target=32'h0000_0400: next pc=32'h400. Then pc=32'hFFFF_FFFC with no control: next pc=0.
- decode_ready=0 for 5 cycles: instr/opcode/func stable, pc unchanged, imem_req=0. Then Halted=1 with decode_ready=1: halted=1, imem_req stays 0 forever, pc frozen.
- imem_ready low for 20 cycles (WAIT_LIMIT=16): fetch_timeout=1 after cycle 16 and stays set. Assert rst_b=0 mid-wait: all outputs return to reset values immediately. With FETCH_INSTR_COUNT_EN, retired_count=3 after three accepted instructions.
